// File: rtl/rv32i_trace_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_trace_pkg
//   Shared types for the rv32i commit-trace buffer.
//   - trace_state_e : capture FSM state, encoding is visible on state_o
//                     (IDLE=0, CAPTURE=1, POST=2, DRAIN=3).
//   - trace_entry_t : one stored commit event {pc, instr, rd, data, ts}.
//   - TRACE_TS_W    : timestamp width used by the stored entry layout; the
//                     top-level TS_W parameter must match it.
// ---------------------------------------------------------------------------
package rv32i_trace_pkg;

    localparam int TRACE_TS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DRAIN   = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [4:0]            rd;
        logic [31:0]           data;
        logic [TRACE_TS_W-1:0] ts;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/rv32i_trace_ram.sv
// ---------------------------------------------------------------------------
// rv32i_trace_ram
//   DEPTH x W register array: one synchronous write port, one asynchronous
//   read port. Contents are not reset; validity is tracked by the owner.
//   Ports:
//     clk_i    clock, rising edge
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module rv32i_trace_ram
    import rv32i_trace_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter int  W     = TRACE_ENTRY_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rv32i_trace_buffer.sv
// ---------------------------------------------------------------------------
// rv32i_trace_buffer
//   Commit-trace capture unit. Records retired-instruction events from the
//   core writeback debug stream into a DEPTH-entry circular buffer, with an
//   optional PC-match trigger, then drains the buffer oldest-first.
//   Ports:
//     clk_i, rst_ni         clock / asynchronous active-low reset
//     arm_i                 1-cycle pulse: clear buffer, start capture
//     mode_i                0 fill-once, 1 circular with trigger (on arm)
//     trig_en_i, trig_pc_i  PC-match trigger config (on arm)
//     post_trig_i           entries kept after the trigger entry (on arm)
//     wb_*_i                commit event stream (valid, pc, instr, rd, data)
//     rd_*                  read port, entry fields + timestamp
//     count_o               entries currently held
//     state_o               FSM state (IDLE=0 CAPTURE=1 POST=2 DRAIN=3)
//     overflow_o            an entry was overwritten since arm (sticky)
//     done_o                1-cycle pulse on DRAIN->IDLE
//
//   Read handshake: an entry transfers on a rising edge where rd_valid_o and
//   rd_ready_i are both high; rd_valid_o never depends on rd_ready_i, and
//   while rd_valid_o is high and rd_ready_i low the rd_* fields hold steady.
//   An arm_i in the same cycle cancels the transfer.
// ---------------------------------------------------------------------------
module rv32i_trace_buffer
    import rv32i_trace_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter int  TS_W  = TRACE_TS_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            arm_i,
    input  logic            mode_i,
    input  logic            trig_en_i,
    input  logic [31:0]     trig_pc_i,
    input  logic [AW:0]     post_trig_i,
    input  logic            wb_valid_i,
    input  logic [31:0]     wb_pc_i,
    input  logic [31:0]     wb_instr_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [31:0]     wb_data_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [31:0]     rd_pc_o,
    output logic [31:0]     rd_instr_o,
    output logic [4:0]      rd_rd_o,
    output logic [31:0]     rd_data_o,
    output logic [TS_W-1:0] rd_ts_o,
    output logic [AW:0]     count_o,
    output logic [1:0]      state_o,
    output logic            overflow_o,
    output logic            done_o
);

    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    trace_state_e    state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_q, post_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            ovf_q, ovf_d;

    // Configuration latched on arm
    logic            cfg_mode_q;
    logic            cfg_trig_en_q;
    logic [31:0]     cfg_trig_pc_q;
    logic [CW-1:0]   cfg_post_q;

    logic            full;
    logic            capturing;
    logic            we;
    logic            trig_hit;
    logic            rd_valid;
    logic            pop;
    logic            done;
    logic [AW-1:0]   rptr;

    trace_entry_t                wr_entry;
    trace_entry_t                rd_entry;
    logic [TRACE_ENTRY_W-1:0]    ram_rdata;

    assign full      = (count_q == FULL);
    assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    // Fill-once never writes into a full buffer; circular mode overwrites.
    assign we        = capturing && wb_valid_i && !arm_i && (cfg_mode_q || !full);
    assign trig_hit  = we && (state_q == ST_CAPTURE) && cfg_mode_q && cfg_trig_en_q
                       && (wb_pc_i == cfg_trig_pc_q);
    assign rd_valid  = (state_q == ST_DRAIN) && (count_q != '0);
    assign pop       = rd_valid && rd_ready_i && !arm_i;
    assign done      = (state_q == ST_DRAIN) && (count_q == '0) && !arm_i;
    // Oldest entry; when full the low bits of count are zero so rptr == wptr.
    assign rptr      = wptr_q - count_q[AW-1:0];

    assign wr_entry = '{pc: wb_pc_i, instr: wb_instr_i, rd: wb_rd_i,
                        data: wb_data_i, ts: ts_q};
    assign rd_entry = ram_rdata;

    rv32i_trace_ram #(
        .DEPTH (DEPTH),
        .W     (TRACE_ENTRY_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr),
        .rdata_o (ram_rdata)
    );

    // Next-state and datapath counters
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        post_d  = post_q;
        ts_d    = ts_q;
        ovf_d   = ovf_q;

        if (arm_i) begin
            state_d = ST_CAPTURE;
            wptr_d  = '0;
            count_d = '0;
            post_d  = '0;
            ts_d    = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_CAPTURE, ST_POST: begin
                    ts_d = ts_q + TS_W'(1);
                    if (we) begin
                        wptr_d = wptr_q + AW'(1);
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    if (state_q == ST_CAPTURE) begin
                        if (we && !cfg_mode_q && (count_q == FULL - CW'(1))) begin
                            state_d = ST_DRAIN;
                        end
                        if (trig_hit) begin
                            if (cfg_post_q == '0) begin
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = ST_POST;
                                post_d  = cfg_post_q;
                            end
                        end
                    end else if (we) begin
                        post_d = post_q - CW'(1);
                        if (post_q == CW'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (pop) begin
                        count_d = count_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
            ts_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            post_q  <= post_d;
            ts_q    <= ts_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_mode_q    <= 1'b0;
            cfg_trig_en_q <= 1'b0;
            cfg_trig_pc_q <= '0;
            cfg_post_q    <= '0;
        end else if (arm_i) begin
            cfg_mode_q    <= mode_i;
            cfg_trig_en_q <= trig_en_i;
            cfg_trig_pc_q <= trig_pc_i;
            cfg_post_q    <= post_trig_i;
        end
    end

    // Fields are forced to zero when nothing is offered so idle outputs are 0.
    assign rd_valid_o = rd_valid;
    assign rd_pc_o    = rd_valid ? rd_entry.pc    : '0;
    assign rd_instr_o = rd_valid ? rd_entry.instr : '0;
    assign rd_rd_o    = rd_valid ? rd_entry.rd    : '0;
    assign rd_data_o  = rd_valid ? rd_entry.data  : '0;
    assign rd_ts_o    = rd_valid ? rd_entry.ts    : '0;
    assign count_o    = count_q;
    assign state_o    = state_q;
    assign overflow_o = ovf_q;
    assign done_o     = done;

endmodule
